// File: rtl/fv_si_pkg.sv
// Shared types for the single-instruction tracker: FSM states, the decoded
// operation enum, the writeback classification and the default timeout.
package fv_si_pkg;

    localparam int SI_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRACK,
        ST_DONE
    } si_state_e;

    typedef enum logic [6:0] {
        OP_NONE,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
        OP_LR, OP_SC, OP_AMO
    } si_op_e;

    // True when the operation writes a non-zero destination register.
    function automatic logic has_rd(input si_op_e op, input logic [4:0] rd);
        case (op)
            OP_NONE,
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
            OP_SB, OP_SH, OP_SW, OP_SD,
            OP_FENCE, OP_ECALL, OP_EBREAK: has_rd = 1'b0;
            default:                       has_rd = (rd != 5'd0);
        endcase
    endfunction

endpackage

// File: rtl/fv_si_decode.sv
// Combinational decoder: instruction word -> operation enum and destination.
module fv_si_decode
    import fv_si_pkg::*;
(
    input  logic [31:0] instr,
    output si_op_e      op,
    output logic [4:0]  rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign alt    = instr[30];
    assign rd     = instr[11:7];

    // Map opcode/funct fields onto the operation enum; unrecognised encodings give OP_NONE.
    always_comb begin
        // NOTE: op gets a default before the case so every path assigns it and no latch is inferred.
        op = OP_NONE;
        case (opcode)
            7'h37: op = OP_LUI;
            7'h17: op = OP_AUIPC;
            7'h6F: op = OP_JAL;
            7'h67: op = OP_JALR;
            7'h0F: op = OP_FENCE;
            7'h63: case (funct3)
                3'd0: op = OP_BEQ;   3'd1: op = OP_BNE;
                3'd4: op = OP_BLT;   3'd5: op = OP_BGE;
                3'd6: op = OP_BLTU;  3'd7: op = OP_BGEU;
                default: op = OP_NONE;
            endcase
            7'h03: case (funct3)
                3'd0: op = OP_LB;    3'd1: op = OP_LH;    3'd2: op = OP_LW;
                3'd3: op = OP_LD;    3'd4: op = OP_LBU;   3'd5: op = OP_LHU;
                3'd6: op = OP_LWU;
                default: op = OP_NONE;
            endcase
            7'h23: case (funct3)
                3'd0: op = OP_SB;    3'd1: op = OP_SH;
                3'd2: op = OP_SW;    3'd3: op = OP_SD;
                default: op = OP_NONE;
            endcase
            7'h13: case (funct3)
                3'd0: op = OP_ADDI;  3'd1: op = OP_SLLI;  3'd2: op = OP_SLTI;
                3'd3: op = OP_SLTIU; 3'd4: op = OP_XORI;  3'd6: op = OP_ORI;
                3'd7: op = OP_ANDI;
                default: op = alt ? OP_SRAI : OP_SRLI;
            endcase
            7'h33: if (funct7 == 7'h01) begin
                case (funct3)
                    3'd0: op = OP_MUL;    3'd1: op = OP_MULH;
                    3'd2: op = OP_MULHSU; 3'd3: op = OP_MULHU;
                    3'd4: op = OP_DIV;    3'd5: op = OP_DIVU;
                    3'd6: op = OP_REM;
                    default: op = OP_REMU;
                endcase
            end else begin
                case (funct3)
                    3'd0: op = alt ? OP_SUB : OP_ADD;
                    3'd1: op = OP_SLL;   3'd2: op = OP_SLT;   3'd3: op = OP_SLTU;
                    3'd4: op = OP_XOR;   3'd5: op = alt ? OP_SRA : OP_SRL;
                    3'd6: op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
            7'h1B: case (funct3)
                3'd0: op = OP_ADDIW;
                3'd1: op = OP_SLLIW;
                3'd5: op = alt ? OP_SRAIW : OP_SRLIW;
                default: op = OP_NONE;
            endcase
            7'h3B: if (funct7 == 7'h01) begin
                case (funct3)
                    3'd0: op = OP_MULW;  3'd4: op = OP_DIVW;  3'd5: op = OP_DIVUW;
                    3'd6: op = OP_REMW;  3'd7: op = OP_REMUW;
                    default: op = OP_NONE;
                endcase
            end else begin
                case (funct3)
                    3'd0: op = alt ? OP_SUBW : OP_ADDW;
                    3'd1: op = OP_SLLW;
                    3'd5: op = alt ? OP_SRAW : OP_SRLW;
                    default: op = OP_NONE;
                endcase
            end
            7'h73: begin
                if (instr[31:7] == 25'h0)
                    op = OP_ECALL;
                else if (instr[31:7] == 25'h0002000)
                    op = OP_EBREAK;
            end
            7'h2F: case (instr[31:27])
                5'b00010: op = OP_LR;
                5'b00011: op = OP_SC;
                default:  op = OP_AMO;
            endcase
            default: op = OP_NONE;
        endcase
    end

endmodule

// File: rtl/fv_si_tracker.sv
// Single-instruction tracker: arms on request, captures the next issued
// instruction, waits for its register writeback and presents the captured
// fields with a one-cycle check pulse (or a sticky timeout).
module fv_si_tracker
    import fv_si_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SI_TIMEOUT = SI_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            si_arm,
    input  logic            iss_valid,
    input  logic [31:0]     iss_instr,
    input  logic [XLEN-1:0] iss_pc,
    input  logic [XLEN-1:0] iss_rs1_value,
    input  logic [XLEN-1:0] iss_rs2_value,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            si_check,
    output si_op_e          si_op,
    output logic [31:0]     si_instr,
    output logic [XLEN-1:0] si_pc,
    output logic [XLEN-1:0] si_rs1_value,
    output logic [XLEN-1:0] si_rs2_value,
    output logic [XLEN-1:0] si_imm12_signed_ext,
    output logic [5:0]      si_shamt,
    output logic [XLEN-1:0] si_rd_value,
    output logic [7:0]      si_latency,
    output logic            si_busy,
    output logic            si_timeout
);

    si_state_e  state;
    si_op_e     dec_op;
    logic [4:0] dec_rd;
    logic [4:0] cap_rd;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    fv_si_decode u_decode (
        .instr (iss_instr),
        .op    (dec_op),
        .rd    (dec_rd)
    );

    assign cnt_inc             = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign si_busy             = (state == ST_ARMED) || (state == ST_TRACK);
    assign si_imm12_signed_ext = {{(XLEN-12){si_instr[31]}}, si_instr[31:20]};
    assign si_shamt            = (XLEN == 64) ? si_instr[25:20] : {1'b0, si_instr[24:20]};

    // Tracking FSM with capture registers, latency counter and check/timeout outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            si_check     <= 1'b0;
            si_op        <= OP_NONE;
            si_instr     <= '0;
            si_pc        <= '0;
            si_rs1_value <= '0;
            si_rs2_value <= '0;
            si_rd_value  <= '0;
            si_latency   <= '0;
            si_timeout   <= 1'b0;
            cap_rd       <= '0;
            cnt          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
            si_check <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (si_arm)
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (iss_valid && !flush) begin
                        si_op        <= dec_op;
                        si_instr     <= iss_instr;
                        si_pc        <= iss_pc;
                        si_rs1_value <= iss_rs1_value;
                        si_rs2_value <= iss_rs2_value;
                        si_rd_value  <= '0;
                        cap_rd       <= dec_rd;
                        cnt          <= '0;
                        if (has_rd(dec_op, dec_rd)) begin
                            state      <= ST_TRACK;
                            si_latency <= 8'd0;
                        end else begin
                            state      <= ST_DONE;
                            si_check   <= 1'b1;
                            si_latency <= 8'd1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (flush) begin
                        state <= ST_ARMED;
                    end else if (wb_valid && (wb_rd == cap_rd)) begin
                        si_rd_value <= wb_value;
                        si_latency  <= cnt_inc;
                        si_check    <= 1'b1;
                        state       <= ST_DONE;
                    end else if (int'(cnt_inc) >= SI_TIMEOUT) begin
                        si_timeout <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fv_si_tracker.sv
// Directed bench for fv_si_tracker: a table of single-instruction transactions
// followed by hand-written sequences for writeback filtering, flush, timeout
// and reset-during-tracking.
module tb_fv_si_tracker;
    import fv_si_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 15;
    localparam int NVEC    = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            si_arm;
    logic            iss_valid;
    logic [31:0]     iss_instr;
    logic [XLEN-1:0] iss_pc;
    logic [XLEN-1:0] iss_rs1_value;
    logic [XLEN-1:0] iss_rs2_value;
    logic            flush;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_value;
    logic            si_check;
    si_op_e          si_op;
    logic [31:0]     si_instr;
    logic [XLEN-1:0] si_pc;
    logic [XLEN-1:0] si_rs1_value;
    logic [XLEN-1:0] si_rs2_value;
    logic [XLEN-1:0] si_imm12_signed_ext;
    logic [5:0]      si_shamt;
    logic [XLEN-1:0] si_rd_value;
    logic [7:0]      si_latency;
    logic            si_busy;
    logic            si_timeout;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          wb_delay;   // 0: no writeback expected
        logic [31:0] wb_value;
        si_op_e      op;
        logic [31:0] rd_value;
        logic [7:0]  latency;
        logic [31:0] imm;
        logic [5:0]  shamt;
    } vec_t;

    vec_t vecs [NVEC];

    fv_si_tracker #(.XLEN(XLEN), .SI_TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .si_arm              (si_arm),
        .iss_valid           (iss_valid),
        .iss_instr           (iss_instr),
        .iss_pc              (iss_pc),
        .iss_rs1_value       (iss_rs1_value),
        .iss_rs2_value       (iss_rs2_value),
        .flush               (flush),
        .wb_valid            (wb_valid),
        .wb_rd               (wb_rd),
        .wb_value            (wb_value),
        .si_check            (si_check),
        .si_op               (si_op),
        .si_instr            (si_instr),
        .si_pc               (si_pc),
        .si_rs1_value        (si_rs1_value),
        .si_rs2_value        (si_rs2_value),
        .si_imm12_signed_ext (si_imm12_signed_ext),
        .si_shamt            (si_shamt),
        .si_rd_value         (si_rd_value),
        .si_latency          (si_latency),
        .si_busy             (si_busy),
        .si_timeout          (si_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        iss_valid     = 1'b1;
        iss_instr     = instr;
        iss_pc        = pc;
        iss_rs1_value = rs1;
        iss_rs2_value = rs2;
    endtask

    task automatic arm();
        si_arm = 1'b1;
        tick();
        si_arm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_check"},   64'(si_check), 64'd0);
        check({tag, "_op"},      64'(si_op), 64'(OP_NONE));
        check({tag, "_instr"},   64'(si_instr), 64'd0);
        check({tag, "_pc"},      64'(si_pc), 64'd0);
        check({tag, "_rs1"},     64'(si_rs1_value), 64'd0);
        check({tag, "_rs2"},     64'(si_rs2_value), 64'd0);
        check({tag, "_imm"},     64'(si_imm12_signed_ext), 64'd0);
        check({tag, "_shamt"},   64'(si_shamt), 64'd0);
        check({tag, "_rdval"},   64'(si_rd_value), 64'd0);
        check({tag, "_lat"},     64'(si_latency), 64'd0);
        check({tag, "_busy"},    64'(si_busy), 64'd0);
        check({tag, "_timeout"}, 64'(si_timeout), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic saw_pulse;

        //              instr          pc           rs1          rs2     dly wb_value      op         rd_value      lat   imm           shamt
        vecs[0]  = '{32'hFFF08293, 32'h100, 32'h10,       32'h0,  3, 32'h0F,       OP_ADDI,   32'h0F,       8'd3, 32'hFFFFFFFF, 6'h1F}; // ADDI x5,x1,-1
        vecs[1]  = '{32'h0020A423, 32'h104, 32'h2000,     32'h77, 0, 32'h0,        OP_SW,     32'h0,        8'd1, 32'h2,        6'h02}; // SW x2,8(x1)
        vecs[2]  = '{32'h022081B3, 32'h108, 32'h6,        32'h7,  5, 32'hDEAD,     OP_MUL,    32'hDEAD,     8'd5, 32'h22,       6'h02}; // MUL x3,x1,x2
        vecs[3]  = '{32'h00208463, 32'h10C, 32'h1,        32'h1,  0, 32'h0,        OP_BEQ,    32'h0,        8'd1, 32'h2,        6'h02}; // BEQ x1,x2,+8
        vecs[4]  = '{32'h00000013, 32'h110, 32'h0,        32'h0,  0, 32'h0,        OP_ADDI,   32'h0,        8'd1, 32'h0,        6'h00}; // NOP (rd=x0)
        vecs[5]  = '{32'h80000537, 32'h114, 32'h0,        32'h0,  1, 32'h80000000, OP_LUI,    32'h80000000, 8'd1, 32'hFFFFF800, 6'h00}; // LUI x10
        vecs[6]  = '{32'h40335313, 32'h118, 32'h91A0,     32'h0,  2, 32'h1234,     OP_SRAI,   32'h1234,     8'd2, 32'h403,      6'h03}; // SRAI x6,x6,3
        vecs[7]  = '{32'h00000073, 32'h11C, 32'h0,        32'h0,  0, 32'h0,        OP_ECALL,  32'h0,        8'd1, 32'h0,        6'h00}; // ECALL
        vecs[8]  = '{32'h00100073, 32'h120, 32'h0,        32'h0,  0, 32'h0,        OP_EBREAK, 32'h0,        8'd1, 32'h1,        6'h01}; // EBREAK
        vecs[9]  = '{32'h0FF0000F, 32'h124, 32'h0,        32'h0,  0, 32'h0,        OP_FENCE,  32'h0,        8'd1, 32'hFF,       6'h1F}; // FENCE
        vecs[10] = '{32'h00012583, 32'h128, 32'h4000,     32'h0,  4, 32'hCAFEF00D, OP_LW,     32'hCAFEF00D, 8'd4, 32'h0,        6'h00}; // LW x11,0(x2)
        vecs[11] = '{32'h1000A62F, 32'h12C, 32'h8000,     32'h0,  1, 32'h77,       OP_LR,     32'h77,       8'd1, 32'h100,      6'h00}; // LR.W x12,(x1)
        vecs[12] = '{32'h002086BB, 32'h130, 32'h1,        32'h2,  1, 32'h99,       OP_ADDW,   32'h99,       8'd1, 32'h2,        6'h02}; // ADDW x13,x1,x2

        reset = 1'b1; si_arm = 1'b0; iss_valid = 1'b0; iss_instr = '0; iss_pc = '0;
        iss_rs1_value = '0; iss_rs2_value = '0; flush = 1'b0; wb_valid = 1'b0;
        wb_rd = '0; wb_value = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", 64'(si_busy), 64'd0);

        // Table-driven transactions
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            arm();
            check($sformatf("v%0d_armed", i), 64'(si_busy), 64'd1);
            issue(v.instr, v.pc, v.rs1, v.rs2);
            tick();
            iss_valid = 1'b0;
            if (v.wb_delay > 0) begin
                check($sformatf("v%0d_track", i), 64'(si_busy), 64'd1);
                repeat (v.wb_delay - 1) tick();
                wb_valid = 1'b1;
                wb_rd    = v.instr[11:7];
                wb_value = v.wb_value;
                tick();
                wb_valid = 1'b0;
            end
            check($sformatf("v%0d_check", i), 64'(si_check), 64'd1);
            check($sformatf("v%0d_op", i),    64'(si_op), 64'(v.op));
            check($sformatf("v%0d_instr", i), 64'(si_instr), 64'(v.instr));
            check($sformatf("v%0d_pc", i),    64'(si_pc), 64'(v.pc));
            check($sformatf("v%0d_rs1", i),   64'(si_rs1_value), 64'(v.rs1));
            check($sformatf("v%0d_rs2", i),   64'(si_rs2_value), 64'(v.rs2));
            check($sformatf("v%0d_rdval", i), 64'(si_rd_value), 64'(v.rd_value));
            check($sformatf("v%0d_lat", i),   64'(si_latency), 64'(v.latency));
            check($sformatf("v%0d_imm", i),   64'(si_imm12_signed_ext), 64'(v.imm));
            check($sformatf("v%0d_shamt", i), 64'(si_shamt), 64'(v.shamt));
            check($sformatf("v%0d_busy", i),  64'(si_busy), 64'd0);
            tick();
            check($sformatf("v%0d_pulse_end", i), 64'(si_check), 64'd0);
            check($sformatf("v%0d_hold", i),      64'(si_rd_value), 64'(v.rd_value));
        end

        // ADD x7: writeback in the capture cycle and to another rd are ignored
        arm();
        issue(32'h002083B3, 32'h200, 32'h5, 32'h6);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_value = 32'h11;
        tick();
        iss_valid = 1'b0;
        wb_rd = 5'd8; wb_value = 32'h22;
        tick();
        wb_valid = 1'b0;
        check("add_no_early", 64'(si_check), 64'd0);
        check("add_busy", 64'(si_busy), 64'd1);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_value = 32'h55;
        tick();
        wb_valid = 1'b0;
        check("add_check", 64'(si_check), 64'd1);
        check("add_op", 64'(si_op), 64'(OP_ADD));
        check("add_rdval", 64'(si_rd_value), 64'h55);
        check("add_lat", 64'(si_latency), 64'd2);

        // MUL x3 flushed; flush beats a matching wb; flushed issue not captured; then SUB x4
        arm();
        issue(32'h022081B3, 32'h300, 32'h3, 32'h4);
        tick();
        iss_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_no_pulse", 64'(si_check), 64'd0);
        check("flush_armed", 64'(si_busy), 64'd1);
        issue(32'h022081B3, 32'h304, 32'h3, 32'h4);
        tick();
        iss_valid = 1'b0;
        flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_value = 32'h12;
        tick();
        flush = 1'b0; wb_valid = 1'b0;
        check("flush_prio_no_pulse", 64'(si_check), 64'd0);
        check("flush_prio_armed", 64'(si_busy), 64'd1);
        check("flush_prio_rdval", 64'(si_rd_value), 64'd0);
        issue(32'h00000013, 32'h308, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        iss_valid = 1'b0; flush = 1'b0;
        check("flush_issue_no_cap", 64'(si_instr), 64'h022081B3);
        check("flush_issue_armed", 64'(si_busy), 64'd1);
        issue(32'h40208233, 32'h30C, 32'h9, 32'h2);
        tick();
        iss_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_value = 32'h44;
        tick();
        wb_valid = 1'b0;
        check("sub_check", 64'(si_check), 64'd1);
        check("sub_op", 64'(si_op), 64'(OP_SUB));
        check("sub_rdval", 64'(si_rd_value), 64'h44);
        check("sub_lat", 64'(si_latency), 64'd1);
        check("sub_pc", 64'(si_pc), 64'h30C);

        // DIV x9 with no writeback: timeout after exactly TIMEOUT cycles
        arm();
        issue(32'h0220C4B3, 32'h400, 32'h64, 32'h5);
        tick();
        iss_valid = 1'b0;
        saw_pulse = 1'b0;
        check("div_op", 64'(si_op), 64'(OP_DIV));
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            saw_pulse = saw_pulse | si_check;
        end
        check("div_pre_timeout", 64'(si_timeout), 64'd0);
        check("div_pre_busy", 64'(si_busy), 64'd1);
        tick();
        saw_pulse = saw_pulse | si_check;
        check("div_timeout", 64'(si_timeout), 64'd1);
        check("div_no_pulse", 64'(saw_pulse), 64'd0);
        check("div_busy", 64'(si_busy), 64'd0);
        arm();
        issue(32'h0020A423, 32'h404, 32'h0, 32'h0);
        tick();
        iss_valid = 1'b0;
        check("sticky_check", 64'(si_check), 64'd1);
        check("sticky_timeout", 64'(si_timeout), 64'd1);

        // Reset while tracking ADDI x5
        arm();
        issue(32'hFFF08293, 32'h500, 32'h10, 32'h0);
        tick();
        iss_valid = 1'b0;
        check("rst_track_busy", 64'(si_busy), 64'd1);
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_value = 32'hF;
        tick();
        reset = 1'b0; wb_valid = 1'b0;
        check_all_zero("rst_track");
        tick();
        check("rst_idle_busy", 64'(si_busy), 64'd0);
        arm();
        check("rst_rearm", 64'(si_busy), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fv_si_tracker.md
FV_SI_TRACKER -- requirements
Module: fv_si_tracker

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register/datapath width (32 or 64).
REQ-002 The block SHALL have parameter SI_TIMEOUT, default 15, meaning the maximum number of cycles from issue to writeback before timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named as the codebase does (clk, reset).
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- si_arm  in  1  track the next issued instruction
- iss_valid  in  1  instruction issues this cycle
- iss_instr  in  32  issued instruction word
- iss_pc  in  XLEN  issued PC
- iss_rs1_value  in  XLEN  rs1 operand at issue
- iss_rs2_value  in  XLEN  rs2 operand at issue
- flush  in  1  pipeline flush, kills the tracked instruction
- wb_valid  in  1  register-file write this cycle
- wb_rd  in  5  write destination
- wb_value  in  XLEN  write data
- si_check  out  1  one-cycle pulse, captured fields valid for checking
- si_op  out  si_op_e  decoded operation
- si_instr  out  32  captured instruction word
- si_pc  out  XLEN  captured PC
- si_rs1_value  out  XLEN  captured rs1 operand
- si_rs2_value  out  XLEN  captured rs2 operand
- si_imm12_signed_ext  out  XLEN  sign-extended instr[31:20]
- si_shamt  out  6  instr[25:20]; bit 5 forced to 0 when XLEN=32
- si_rd_value  out  XLEN  observed writeback value
- si_latency  out  8  cycles from issue to writeback
- si_busy  out  1  state is ARMED or TRACK
- si_timeout  out  1  sticky: no writeback observed within SI_TIMEOUT

Function
REQ-005 The FSM SHALL have states IDLE, ARMED, TRACK, DONE; reset enters IDLE.
REQ-006 In IDLE or DONE, si_arm=1 SHALL move the FSM to ARMED next cycle; si_arm SHALL be ignored in ARMED and TRACK.
REQ-007 In ARMED with iss_valid=1, the block SHALL capture instr, pc, rs1, rs2, decoded op and rd, and clear the latency counter to 0; if flush=1 in the same cycle, the FSM SHALL stay in ARMED and not capture.
REQ-008 On capture of an op with a writeback (rd!=0, not branch/store/fence/ecall/ebreak), the FSM SHALL enter TRACK; otherwise it SHALL enter DONE with si_check pulsed in the next cycle, si_rd_value=0 and si_latency=1.
REQ-009 In TRACK, the latency counter SHALL increment by 1 per cycle, saturating at 255.
REQ-010 In TRACK, the first cycle with wb_valid=1 and wb_rd=captured rd SHALL latch wb_value into si_rd_value and the count+1 into si_latency, enter DONE, and pulse si_check for exactly one cycle (the first DONE cycle).
REQ-011 A writeback in the capture cycle itself SHALL be ignored (it belongs to an older instruction).
REQ-012 flush=1 in TRACK SHALL return the FSM to ARMED without a si_check pulse; flush SHALL take priority over a same-cycle matching writeback.
REQ-013 If the counter reaches SI_TIMEOUT in TRACK with no match, the block SHALL set si_timeout, enter DONE, and emit no si_check pulse.
REQ-014 Captured outputs SHALL hold stable from capture until the next capture or reset.
REQ-015 Sign-extension SHALL use instr[31] replicated to XLEN.

Reset
REQ-016 Reset SHALL force IDLE, and all outputs SHALL be 0 (si_op=OP_NONE, si_timeout=0), overriding any in-flight tracking.
REQ-017 si_timeout SHALL clear only on reset.

Structure
REQ-018 Package fv_si_pkg SHALL hold the si_op_e enum (RV32I/M/A/RV64 ops plus OP_NONE), the has_rd classification function, and the default SI_TIMEOUT.
REQ-019 The design SHALL use one sub-module, fv_si_decode: combinational iss_instr -> si_op_e and rd.

Verification
REQ-020 The bench SHALL cover: arm; issue ADDI x5,x1,-1 with rs1=0x10; wb x5=0x0F three cycles later -> si_check pulse, si_rd_value=0x0F, si_latency=3, si_imm12_signed_ext=0xFFFFFFFF.
REQ-021 The bench SHALL cover: arm; issue SW -> si_check on the next cycle, si_op=OP_SW, si_rd_value=0, si_latency=1.
REQ-022 The bench SHALL cover: arm; issue ADD x7; wb x7 in the issue cycle and again at +2 with 0x55 -> only the +2 write is captured, si_rd_value=0x55.
REQ-023 The bench SHALL cover: arm; issue MUL x3; flush at +1 -> no pulse and back to ARMED; next issue SUB x4 with wb at +1 -> pulse, si_op=OP_SUB.
REQ-024 The bench SHALL cover: arm; issue DIV x9 with no wb for 15 cycles -> si_timeout=1, no pulse, si_busy=0.
REQ-025 The bench SHALL cover: reset asserted in TRACK -> next cycle all outputs 0 and state IDLE.
